// File: rtl/uart_rx_status_if.sv
// =============================================================================
// uart_rx_status_if: host/FIFO-side signal bundle for the RX status stage.
// Rev 1.0
// =============================================================================
`default_nettype none

interface uart_rx_status_if #(
    parameter int REC_W = 10,
    parameter int CNT_W = 5
);
    logic             rbr_read;
    logic             lsr_read;
    logic [1:0]       fcr_trig;
    logic             ier_rda;
    logic             ier_rls;
    logic             thre_i;
    logic             temt_i;
    logic [REC_W-1:0] rf_data_out;
    logic [CNT_W-1:0] rf_count;
    logic             rf_error_bit;
    logic             rf_overrun;
    logic [5:0]       counter_t;

    logic             rf_pop;
    logic [7:0]       rbr_data;
    logic [7:0]       lsr;
    logic             rda_int;
    logic             ti_int;
    logic             rls_int;
    logic [3:0]       iir_rx;
    logic             rx_lsr_mask;

    modport slave (
        input  rbr_read, lsr_read, fcr_trig, ier_rda, ier_rls, thre_i, temt_i,
               rf_data_out, rf_count, rf_error_bit, rf_overrun, counter_t,
        output rf_pop, rbr_data, lsr, rda_int, ti_int, rls_int, iir_rx, rx_lsr_mask
    );

    modport master (
        output rbr_read, lsr_read, fcr_trig, ier_rda, ier_rls, thre_i, temt_i,
               rf_data_out, rf_count, rf_error_bit, rf_overrun, counter_t,
        input  rf_pop, rbr_data, lsr, rda_int, ti_int, rls_int, iir_rx, rx_lsr_mask
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_status.sv
// =============================================================================
// uart_rx_status: RX line-status bits, FIFO pop and receive interrupts.
// Optional feature macro: UART_RX_TIMEOUT_EN (character-timeout interrupt).
// Rev 1.0
// =============================================================================
`default_nettype none

module uart_rx_status #(
    parameter int REC_W = 10,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    uart_rx_status_if.slave    bus
);

    localparam logic [3:0] IIR_RLS  = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_TI   = 4'b1100;
    localparam logic [3:0] IIR_NONE = 4'b0001;

    logic [REC_W-1:0] head;
    logic [CNT_W-1:0] trig_lvl;
    logic             count_nz;
    logic             head_valid;
    logic             ovr_rise;

    logic       rf_pop;
    logic [7:0] rbr_data;
    logic       dr, oe, pe, fe, bi, thre, temt, fifo_err;
    logic       ovr_d;
    logic       eval;
    logic       rda_int, ti_int, rls_int;
    logic [3:0] iir_rx;
    logic       rx_lsr_mask;

    assign head       = bus.rf_data_out;
    assign count_nz   = (bus.rf_count != '0);
    assign head_valid = eval && count_nz;
    assign ovr_rise   = bus.rf_overrun && !ovr_d;

    always_comb begin
        trig_lvl = CNT_W'(1);
        case (bus.fcr_trig)
            2'b00:   trig_lvl = CNT_W'(1);
            2'b01:   trig_lvl = CNT_W'(4);
            2'b10:   trig_lvl = CNT_W'(8);
            default: trig_lvl = CNT_W'(14);
        endcase
    end

    // dr doubles as the previous-cycle "FIFO non-empty" for the 0->nonzero detect.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rf_pop      <= 1'b0;
            rbr_data    <= 8'h00;
            dr          <= 1'b0;
            oe          <= 1'b0;
            pe          <= 1'b0;
            fe          <= 1'b0;
            bi          <= 1'b0;
            thre        <= 1'b1;
            temt        <= 1'b1;
            fifo_err    <= 1'b0;
            ovr_d       <= 1'b0;
            eval        <= 1'b0;
            rx_lsr_mask <= 1'b0;
        end else begin
            rf_pop      <= bus.rbr_read && count_nz;
            if (bus.rbr_read && count_nz)
                rbr_data <= head[9:2];
            dr          <= count_nz;
            thre        <= bus.thre_i;
            temt        <= bus.temt_i;
            fifo_err    <= bus.rf_error_bit;
            ovr_d       <= bus.rf_overrun;
            eval        <= rf_pop || (count_nz && !dr);
            rx_lsr_mask <= bus.lsr_read;

            oe <= ovr_rise || (oe && !bus.lsr_read);
            // A head evaluation landing on an LSR read still reports its errors.
            pe <= (head_valid && head[1]) || (pe && !bus.lsr_read);
            fe <= (head_valid && head[0]) || (fe && !bus.lsr_read);
            bi <= (head_valid && head[0] && (head[9:2] == 8'h00)) || (bi && !bus.lsr_read);
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rda_int <= 1'b0;
            rls_int <= 1'b0;
        end else begin
            rda_int <= bus.ier_rda && (bus.rf_count >= trig_lvl);
            rls_int <= bus.ier_rls && (oe || pe || fe || bi);
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i)
            ti_int <= 1'b0;
        else if (bus.rbr_read || !count_nz || !bus.ier_rda)
            ti_int <= 1'b0;
        else if (bus.counter_t == 6'd0)
            ti_int <= 1'b1;
    end
`else
    logic unused_counter_t;
    assign unused_counter_t = ^bus.counter_t;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i)
            ti_int <= 1'b0;
        else
            ti_int <= 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i)
            iir_rx <= IIR_NONE;
        else if (rls_int)
            iir_rx <= IIR_RLS;
        else if (rda_int)
            iir_rx <= IIR_RDA;
        else if (ti_int)
            iir_rx <= IIR_TI;
        else
            iir_rx <= IIR_NONE;
    end

    assign bus.rf_pop      = rf_pop;
    assign bus.rbr_data    = rbr_data;
    assign bus.lsr         = {fifo_err, temt, thre, bi, fe, pe, oe, dr};
    assign bus.rda_int     = rda_int;
    assign bus.ti_int      = ti_int;
    assign bus.rls_int     = rls_int;
    assign bus.iir_rx      = iir_rx;
    assign bus.rx_lsr_mask = rx_lsr_mask;

endmodule

`default_nettype wire
